sw_prio_debounce: RTL and testbench

Input stage that feeds the 3-bit seven-segment decoder. Synchronises and debounces eight slide switches, priority-encodes the highest asserted switch to a 3-bit index, and registers it as `bcd` with a `valid` flag. Also emits a one-cycle `changed` pulse and keeps a wrapping change counter for status LEDs.

---
 rtl/sw_prio_debounce.sv | 180 ++++++++++++++++++
 tb/tb_sw_prio_debounce.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_prio_debounce.sv
// sw_prio_debounce
// ----------------
// Front end for the 3-bit seven-segment decoder. Eight raw slide switches
// are synchronised, debounced as a whole vector, priority-encoded (bit 7
// wins) and presented as a registered 3-bit index with a valid flag. A
// one-cycle pulse marks every change of the registered {bcd, valid} pair,
// and a wrapping counter tallies those pulses for status LEDs.
//
// Parameters
//   DB_CYCLES : debounce length, 1..255. A new vector is accepted once the
//               synchronised value has been stable for DB_CYCLES+1 edges.
// Ports
//   clk       : single clock
//   rst_n     : synchronous, active-low reset
//   sw[7:0]   : raw asynchronous switch levels
//   en        : output-register update enable
//   bcd[2:0]  : index of highest set debounced switch (0 when none)
//   valid     : 1 when any debounced switch is set
//   changed   : one-cycle pulse when {bcd, valid} loads a new value
//   chg_cnt   : count of changed pulses, modulo 256

module sw_prio_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       en,
    output logic [2:0] bcd,
    output logic       valid,
    output logic       changed,
    output logic [7:0] chg_cnt
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    // Priority encoder: returns {index[2:0], any_set}; all zero for no switch.
    function automatic logic [3:0] prio_enc(input logic [7:0] v);
        logic [3:0] r;
        r = 4'b0000;
        casez (v)
            8'b1???????: r = 4'b1111;
            8'b01??????: r = 4'b1101;
            8'b001?????: r = 4'b1011;
            8'b0001????: r = 4'b1001;
            8'b00001???: r = 4'b0111;
            8'b000001??: r = 4'b0101;
            8'b0000001?: r = 4'b0011;
            8'b00000001: r = 4'b0001;
            default:     r = 4'b0000;
        endcase
        return r;
    endfunction

    logic [7:0]    s1_r;
    logic [7:0]    s2_r;
    logic [7:0]    deb_r;
    logic [7:0]    cand_r;
    logic [CW-1:0] cnt_r;
    state_t        state_r;

    state_t        state_nx_s;
    logic [7:0]    deb_nx_s;
    logic [7:0]    cand_nx_s;
    logic [CW-1:0] cnt_nx_s;

    logic [3:0]    enc_s;
    logic [2:0]    enc_idx_s;
    logic          enc_v_s;

    logic [2:0]    bcd_r;
    logic          valid_r;
    logic          changed_r;
    logic [7:0]    chg_cnt_r;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r <= 8'h00;
            s2_r <= 8'h00;
        end else begin
            s1_r <= sw;
            s2_r <= s1_r;
        end
    end

    // Debounce FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_STABLE;
            deb_r   <= 8'h00;
            cand_r  <= 8'h00;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            deb_r   <= deb_nx_s;
            cand_r  <= cand_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Debounce FSM next state. Any new candidate restarts the count; falling
    // back to the accepted vector cancels the settle without touching deb.
    always_comb begin
        state_nx_s = state_r;
        deb_nx_s   = deb_r;
        cand_nx_s  = cand_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_STABLE: begin
                if (s2_r != deb_r) begin
                    state_nx_s = ST_SETTLE;
                    cand_nx_s  = s2_r;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_STABLE;
                end
            end
            ST_SETTLE: begin
                if (s2_r == deb_r) begin
                    state_nx_s = ST_STABLE;
                end else if (s2_r != cand_r) begin
                    cand_nx_s  = s2_r;
                    cnt_nx_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    deb_nx_s   = cand_r;
                    state_nx_s = ST_STABLE;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_STABLE;
            end
        endcase
    end

    // Encoder view of the accepted vector.
    always_comb begin
        enc_s     = prio_enc(deb_r);
        enc_idx_s = enc_s[3:1];
        enc_v_s   = enc_s[0];
    end

    // Output register, change pulse and change counter. The pulse is raised
    // only when the loaded pair differs from the held pair, so deb changes
    // that keep the same top switch stay silent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_r     <= 3'd0;
            valid_r   <= 1'b0;
            changed_r <= 1'b0;
            chg_cnt_r <= 8'd0;
        end else if (en) begin
            bcd_r   <= enc_idx_s;
            valid_r <= enc_v_s;
            if ({enc_idx_s, enc_v_s} != {bcd_r, valid_r}) begin
                changed_r <= 1'b1;
                chg_cnt_r <= chg_cnt_r + 8'd1;
            end else begin
                changed_r <= 1'b0;
            end
        end else begin
            changed_r <= 1'b0;
        end
    end

    assign bcd     = bcd_r;
    assign valid   = valid_r;
    assign changed = changed_r;
    assign chg_cnt = chg_cnt_r;

endmodule

// File: tb/tb_sw_prio_debounce.sv
// Bench for sw_prio_debounce. Inputs are driven at the falling edge, outputs
// sampled at the falling edge (half a period after the active edge).
// Expected change events {bcd, valid, chg_cnt} are queued when stimulus is
// applied; a monitor pops one per observed changed pulse.

module tb_sw_prio_debounce;

    localparam int DB = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic       en;
    logic [2:0] bcd;
    logic       valid;
    logic       changed;
    logic [7:0] chg_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic        mon_on   = 1'b0;
    logic [7:0]  exp_cnt  = 8'd0;
    logic [11:0] exp_q[$];

    sw_prio_debounce #(.DB_CYCLES(DB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .en      (en),
        .bcd     (bcd),
        .valid   (valid),
        .changed (changed),
        .chg_cnt (chg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every changed pulse must match the next queued event.
    always @(negedge clk) begin
        logic [11:0] e;
        if (mon_on && changed === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: got bcd=%0d valid=%0d chg_cnt=%0d, required no pulse", bcd, valid, chg_cnt);
            end else begin
                e = exp_q.pop_front();
                if ({bcd, valid, chg_cnt} !== e) begin
                    failures++;
                    $display("FAIL pulse_value: got bcd=%0d valid=%0d chg_cnt=%0d, required bcd=%0d valid=%0d chg_cnt=%0d",
                             bcd, valid, chg_cnt, e[11:9], e[8], e[7:0]);
                end
            end
        end
    end

    task automatic expect_change(input logic [2:0] b, input logic v);
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back({b, v, exp_cnt});
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        sw = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw    = 8'hFF;
        en    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mon_on = 1'b1;
            checks++;
            if ({bcd, valid, changed, chg_cnt} !== 13'd0) begin
                failures++;
                $display("FAIL reset_outputs: got bcd=%0d valid=%0d changed=%0d chg_cnt=%0d, required all 0", bcd, valid, changed, chg_cnt);
            end
        end
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        expect_change(3'd7, 1'b1);
        for (int e = 0; e < 7; e++) begin
            @(negedge clk);
            checks++;
            if ({bcd, valid, changed} !== 5'd0) begin
                failures++;
                $display("FAIL accept_early edge %0d: got bcd=%0d valid=%0d changed=%0d, required 0/0/0", e, bcd, valid, changed);
            end
        end
        @(negedge clk);
        checks++;
        if (bcd !== 3'd7 || valid !== 1'b1 || changed !== 1'b1 || chg_cnt !== 8'd1) begin
            failures++;
            $display("FAIL accept_edge7: got bcd=%0d valid=%0d changed=%0d chg_cnt=%0d, required 7/1/1/1", bcd, valid, changed, chg_cnt);
        end
        @(negedge clk);
        checks++;
        if (changed !== 1'b0 || chg_cnt !== 8'd1) begin
            failures++;
            $display("FAIL accept_pulse_width: got changed=%0d chg_cnt=%0d, required 0/1", changed, chg_cnt);
        end
    endtask

    task automatic test_priority();
        logic [7:0] start;
        start = exp_cnt;
        expect_change(3'd5, 1'b1);
        hold(8'b0010_0100, 12);
        checks++;
        if (bcd !== 3'd5 || valid !== 1'b1) begin
            failures++;
            $display("FAIL prio_5: got bcd=%0d valid=%0d, required 5/1", bcd, valid);
        end
        expect_change(3'd0, 1'b1);
        hold(8'b0000_0001, 12);
        checks++;
        if (bcd !== 3'd0 || valid !== 1'b1) begin
            failures++;
            $display("FAIL prio_0: got bcd=%0d valid=%0d, required 0/1", bcd, valid);
        end
        expect_change(3'd0, 1'b0);
        hold(8'h00, 12);
        checks++;
        if (bcd !== 3'd0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL prio_none: got bcd=%0d valid=%0d, required 0/0", bcd, valid);
        end
        checks++;
        if (chg_cnt !== start + 8'd3) begin
            failures++;
            $display("FAIL prio_count: got chg_cnt=%0d, required %0d", chg_cnt, start + 8'd3);
        end
    endtask

    task automatic test_glitch();
        hold(8'h08, DB);
        hold(8'h00, 12);
        checks++;
        if (bcd !== 3'd0 || valid !== 1'b0 || chg_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL glitch_reject: got bcd=%0d valid=%0d chg_cnt=%0d, required 0/0/%0d", bcd, valid, chg_cnt, exp_cnt);
        end
        expect_change(3'd3, 1'b1);
        hold(8'h08, DB + 1);
        hold(8'h00, 3);
        checks++;
        if (bcd !== 3'd3 || valid !== 1'b1 || changed !== 1'b1) begin
            failures++;
            $display("FAIL glitch_accept: got bcd=%0d valid=%0d changed=%0d, required 3/1/1", bcd, valid, changed);
        end
        expect_change(3'd0, 1'b0);
        hold(8'h00, 12);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 5; i++) begin
            hold((i % 2 == 0) ? 8'h10 : 8'h30, 2);
        end
        sw = 8'h30;
        expect_change(3'd5, 1'b1);
        for (int e = 0; e < 7; e++) begin
            @(negedge clk);
            checks++;
            if (bcd !== 3'd0 || valid !== 1'b0) begin
                failures++;
                $display("FAIL bounce_early edge %0d: got bcd=%0d valid=%0d, required 0/0", e, bcd, valid);
            end
        end
        @(negedge clk);
        checks++;
        if (bcd !== 3'd5 || valid !== 1'b1 || changed !== 1'b1) begin
            failures++;
            $display("FAIL bounce_commit: got bcd=%0d valid=%0d changed=%0d, required 5/1/1", bcd, valid, changed);
        end
        hold(8'h30, 4);
    endtask

    task automatic test_enable();
        expect_change(3'd1, 1'b1);
        hold(8'h02, 12);
        en = 1'b0;
        sw = 8'h40;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bcd !== 3'd1 || valid !== 1'b1 || changed !== 1'b0) begin
                failures++;
                $display("FAIL enable_hold cycle %0d: got bcd=%0d valid=%0d changed=%0d, required 1/1/0", i, bcd, valid, changed);
            end
        end
        en = 1'b1;
        expect_change(3'd6, 1'b1);
        @(negedge clk);
        checks++;
        if (bcd !== 3'd6 || valid !== 1'b1 || changed !== 1'b1) begin
            failures++;
            $display("FAIL enable_rise: got bcd=%0d valid=%0d changed=%0d, required 6/1/1", bcd, valid, changed);
        end
        @(negedge clk);
        checks++;
        if (changed !== 1'b0) begin
            failures++;
            $display("FAIL enable_pulse_width: got changed=%0d, required 0", changed);
        end
    endtask

    task automatic test_wrap_reset();
        sw    = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 8'd0;
        checks++;
        if ({bcd, valid, changed, chg_cnt} !== 13'd0) begin
            failures++;
            $display("FAIL wrap_pre_reset: got bcd=%0d valid=%0d changed=%0d chg_cnt=%0d, required all 0", bcd, valid, changed, chg_cnt);
        end
        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 0) begin
                expect_change(3'd0, 1'b1);
                hold(8'h01, 8);
            end else begin
                expect_change(3'd1, 1'b1);
                hold(8'h02, 8);
            end
        end
        checks++;
        if (chg_cnt !== 8'd0 || bcd !== 3'd1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_count: got chg_cnt=%0d bcd=%0d valid=%0d, required 0/1/1", chg_cnt, bcd, valid);
        end
        // Enter SETTLE (edge t+2) then reset at edge t+3, before the commit.
        hold(8'h80, 3);
        rst_n = 1'b0;
        sw    = 8'h00;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 8'd0;
        checks++;
        if ({bcd, valid, changed, chg_cnt} !== 13'd0) begin
            failures++;
            $display("FAIL settle_reset: got bcd=%0d valid=%0d changed=%0d chg_cnt=%0d, required all 0", bcd, valid, changed, chg_cnt);
        end
        hold(8'h00, 12);
        checks++;
        if ({bcd, valid, changed, chg_cnt} !== 13'd0) begin
            failures++;
            $display("FAIL settle_no_commit: got bcd=%0d valid=%0d changed=%0d chg_cnt=%0d, required all 0", bcd, valid, changed, chg_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 8'h00;
        en    = 1'b1;
        test_reset();
        test_priority();
        test_glitch();
        test_bounce();
        test_enable();
        test_wrap_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses: got %0d expected events never seen, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
